// File: rtl/mp64_dma_arb_pkg.sv
// Shared constants, state encoding and transfer payload for the mp64 DMA arbiter.
package mp64_dma_arb_pkg;

  localparam int unsigned DARB_IDX_W  = 3;
  localparam int unsigned DARB_EXT_W  = 1 << DARB_IDX_W;
  localparam int unsigned DARB_ADDR_W = 64;
  localparam int unsigned DARB_DATA_W = 8;
  localparam int unsigned DARB_BCNT_W = 8;
  localparam int unsigned DARB_TO_W   = 16;

  localparam int unsigned DARB_MAX_BURST_DEF = 16;
  localparam int unsigned DARB_TIMEOUT_DEF   = 1024;

  // Requester index map
  localparam int unsigned DARB_REQ_NIC_RX  = 0;
  localparam int unsigned DARB_REQ_NIC_TX  = 1;
  localparam int unsigned DARB_REQ_STORAGE = 2;
  localparam int unsigned DARB_REQ_SPARE   = 3;

  typedef enum logic [1:0] {
    DARB_IDLE = 2'd0,
    DARB_BUSY = 2'd1,
    DARB_GAP  = 2'd2
  } darb_state_e;

  typedef struct packed {
    logic [DARB_ADDR_W-1:0] addr;
    logic [DARB_DATA_W-1:0] wdata;
    logic                   wen;
  } darb_xfer_t;

  // Next requester index with wrap at n.
  function automatic logic [DARB_IDX_W-1:0] darb_next_idx(input logic [DARB_IDX_W-1:0] idx,
                                                         input int unsigned n);
    return (32'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/mp64_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, with wrap.
module mp64_rr_pick
  import mp64_dma_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]      req,
  input  logic [DARB_IDX_W-1:0] start,
  output logic                  found_c,
  output logic [DARB_IDX_W-1:0] idx_c
);

  logic [DARB_EXT_W-1:0] req_ext;
  logic [DARB_IDX_W-1:0] cur;

  assign req_ext = DARB_EXT_W'(req);

  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    cur     = start;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found_c && req_ext[cur]) begin
        found_c = 1'b1;
        idx_c   = cur;
      end
      cur = darb_next_idx(cur, N_REQ);
    end
  end

endmodule

// File: rtl/mp64_dma_arb.sv
// Round-robin DMA arbiter with burst hold and bus timeout, sharing one byte-wide
// memory DMA port among N_REQ requesters.
module mp64_dma_arb
  import mp64_dma_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = DARB_MAX_BURST_DEF,
  parameter int unsigned TIMEOUT   = DARB_TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             r_req,
  input  logic [DARB_ADDR_W*N_REQ-1:0] r_addr,
  input  logic [DARB_DATA_W*N_REQ-1:0] r_wdata,
  input  logic [N_REQ-1:0]             r_wen,
  output logic [N_REQ-1:0]             r_ack,
  output logic [N_REQ-1:0]             r_err,
  output logic [DARB_DATA_W-1:0]       r_rdata,
  output logic                         mem_req,
  output logic [DARB_ADDR_W-1:0]       mem_addr,
  output logic [DARB_DATA_W-1:0]       mem_wdata,
  output logic                         mem_wen,
  input  logic [DARB_DATA_W-1:0]       mem_rdata,
  input  logic                         mem_ack,
  output logic                         busy,
  output logic [DARB_IDX_W-1:0]        grant_id
);

  darb_state_e            state_q, state_d;
  darb_xfer_t             xfer_q, xfer_d;
  logic                   mem_req_q, mem_req_d;
  logic [N_REQ-1:0]       r_ack_q, r_ack_d;
  logic [N_REQ-1:0]       r_err_q, r_err_d;
  logic [DARB_DATA_W-1:0] r_rdata_q, r_rdata_d;
  logic                   busy_q, busy_d;
  logic [DARB_IDX_W-1:0]  grant_id_q, grant_id_d;
  logic [DARB_IDX_W-1:0]  ptr_q, ptr_d;
  logic                   owner_vld_q, owner_vld_d;
  logic [DARB_BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [DARB_TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic [DARB_EXT_W-1:0]  req_ext;
  logic                   hold_c;
  logic                   pick_found_c;
  logic [DARB_IDX_W-1:0]  pick_idx_c;
  logic [DARB_IDX_W-1:0]  win_c;
  darb_xfer_t             sel_c;
  logic [N_REQ-1:0]       owner_oh_c;

  assign req_ext = DARB_EXT_W'(r_req);

  // The current owner keeps the port while it requests and its burst has room.
  assign hold_c = owner_vld_q && req_ext[grant_id_q] &&
                  (burst_cnt_q < DARB_BCNT_W'(MAX_BURST));
  assign win_c  = hold_c ? grant_id_q : pick_idx_c;

  mp64_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req     (r_req),
    .start   (ptr_q),
    .found_c (pick_found_c),
    .idx_c   (pick_idx_c)
  );

  // Winner's request fields, captured only at grant.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_c == DARB_IDX_W'(i)) begin
        sel_c.addr  = r_addr[DARB_ADDR_W*i +: DARB_ADDR_W];
        sel_c.wdata = r_wdata[DARB_DATA_W*i +: DARB_DATA_W];
        sel_c.wen   = r_wen[i];
      end
    end
  end

  always_comb begin
    owner_oh_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      owner_oh_c[i] = (grant_id_q == DARB_IDX_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    mem_req_d   = mem_req_q;
    r_ack_d     = '0;
    r_err_d     = '0;
    r_rdata_d   = r_rdata_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    owner_vld_d = owner_vld_q;
    burst_cnt_d = burst_cnt_q;
    to_cnt_d    = to_cnt_q;

    unique case (state_q)
      DARB_IDLE: begin
        if (hold_c || pick_found_c) begin
          xfer_d      = sel_c;
          mem_req_d   = 1'b1;
          grant_id_d  = win_c;
          ptr_d       = darb_next_idx(win_c, N_REQ);
          owner_vld_d = 1'b1;
          to_cnt_d    = '0;
          state_d     = DARB_BUSY;
          if (!hold_c) begin
            burst_cnt_d = '0;
          end
        end else begin
          owner_vld_d = 1'b0;
        end
      end

      DARB_BUSY: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // A late ack in the timeout cycle still completes normally.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          r_ack_d   = owner_oh_c;
          r_rdata_d = mem_rdata;
          state_d   = DARB_GAP;
          if (burst_cnt_q != '1) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (to_cnt_q == DARB_TO_W'(TIMEOUT - 1)) begin
          mem_req_d   = 1'b0;
          r_ack_d     = owner_oh_c;
          r_err_d     = owner_oh_c;
          r_rdata_d   = '0;
          owner_vld_d = 1'b0;
          state_d     = DARB_GAP;
        end
      end

      DARB_GAP: begin
        // Request levels are stale this cycle; requesters update them on ack.
        state_d = DARB_IDLE;
      end

      default: begin
        state_d = DARB_IDLE;
      end
    endcase

    busy_d = (state_d != DARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DARB_IDLE;
      xfer_q      <= '0;
      mem_req_q   <= 1'b0;
      r_ack_q     <= '0;
      r_err_q     <= '0;
      r_rdata_q   <= '0;
      busy_q      <= 1'b0;
      grant_id_q  <= '0;
      ptr_q       <= '0;
      owner_vld_q <= 1'b0;
      burst_cnt_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      xfer_q      <= xfer_d;
      mem_req_q   <= mem_req_d;
      r_ack_q     <= r_ack_d;
      r_err_q     <= r_err_d;
      r_rdata_q   <= r_rdata_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
      owner_vld_q <= owner_vld_d;
      burst_cnt_q <= burst_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign r_ack     = r_ack_q;
  assign r_err     = r_err_q;
  assign r_rdata   = r_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = xfer_q.addr;
  assign mem_wdata = xfer_q.wdata;
  assign mem_wen   = xfer_q.wen;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_mp64_dma_arb.sv
// Scoreboard bench for mp64_dma_arb: expected grants and completions are queued by
// the stimulus and popped by independent monitors as the DUT presents them.
module tb_mp64_dma_arb;
  import mp64_dma_arb_pkg::*;

  localparam int unsigned N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      r_req = '0;
  logic [64*N-1:0]   r_addr = '0;
  logic [8*N-1:0]    r_wdata = '0;
  logic [N-1:0]      r_wen = '0;
  logic [N-1:0]      r_ack;
  logic [N-1:0]      r_err;
  logic [7:0]        r_rdata;
  logic              mem_req;
  logic [63:0]       mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_wen;
  logic [7:0]        mem_rdata = 8'hEE;
  logic              mem_ack = 1'b0;
  logic              busy;
  logic [2:0]        grant_id;

  mp64_dma_arb #(.N_REQ(N), .MAX_BURST(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .r_req(r_req), .r_addr(r_addr), .r_wdata(r_wdata),
    .r_wen(r_wen), .r_ack(r_ack), .r_err(r_err), .r_rdata(r_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [63:0] addr;
    logic       wen;
    logic [7:0] wdata;
    int         len;
  } gexp_t;

  typedef struct {
    int         id;
    logic       err;
    logic [7:0] rdata;
  } aexp_t;

  gexp_t gq[$];
  aexp_t aq[$];
  int    mdly_q[$];

  int errors = 0;
  int checks = 0;

  int          rem[N] = '{default: 0};
  logic [63:0] q_addr[N] = '{default: '0};
  logic        q_wen[N] = '{default: 1'b0};
  logic [7:0]  q_wdata[N] = '{default: '0};

  localparam logic [63:0] A0 = 64'h8000_0000_0000_0020;
  localparam logic [63:0] A1 = 64'h7700_1234_0000_0041;
  localparam logic [63:0] A2 = 64'h0000_0000_0000_1000;
  localparam logic [63:0] A3 = 64'hFFFF_0000_0000_0083;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  function automatic logic [N-1:0] oh(input int id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] mem_resp(input logic [63:0] a);
    return (a == A2) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  task automatic push_g(input int id, input logic [63:0] addr, input logic wen,
                        input logic [7:0] wdata, input int len);
    gexp_t g;
    g.id = id; g.addr = addr; g.wen = wen; g.wdata = wdata; g.len = len;
    gq.push_back(g);
  endtask

  task automatic push_a(input int id, input logic err, input logic [7:0] rdata);
    aexp_t a;
    a.id = id; a.err = err; a.rdata = rdata;
    aq.push_back(a);
  endtask

  task automatic set_req(input int id, input int n, input logic [63:0] addr,
                         input logic wen, input logic [7:0] wdata);
    q_addr[id]  = addr;
    q_wen[id]   = wen;
    q_wdata[id] = wdata;
    rem[id]     = n;
  endtask

  function automatic bit all_done();
    bit d;
    d = !busy && !mem_req && (gq.size() == 0) && (aq.size() == 0);
    for (int i = 0; i < N; i++) if (rem[i] != 0) d = 1'b0;
    return d;
  endfunction

  // Waits for all traffic to drain, then leaves idle cycles so no burst owner carries over.
  task automatic wait_done(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #2;
      done = all_done();
    end
    if (!done) fail_evt({name, "_timeout"}, 64'(gq.size() + aq.size()));
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Requesters: hold request until acked, one transfer per ack.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (r_ack[i] === 1'b1 && rem[i] > 0) rem[i]--;
      r_req[i]             = (rem[i] > 0);
      r_addr[64*i +: 64]   = q_addr[i];
      r_wdata[8*i +: 8]    = q_wdata[i];
      r_wen[i]             = q_wen[i];
    end
  end

  // Memory slave: ack in the d-th cycle of mem_req; d=0 never acks.
  int   mem_n = 0;
  int   mem_d = 2;
  logic mem_acked = 1'b0;
  initial forever begin
    @(negedge clk);
    if (mem_req === 1'b1 && !mem_acked) begin
      if (mem_n == 0) mem_d = (mdly_q.size() != 0) ? mdly_q.pop_front() : 2;
      mem_n++;
      if (mem_d != 0 && mem_n == mem_d) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_resp(mem_addr);
        mem_acked = 1'b1;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'hEE;
      if (mem_req !== 1'b1) begin
        mem_n     = 0;
        mem_acked = 1'b0;
      end
    end
  end

  // Grant monitor: checks each new transfer and how long mem_req stayed high.
  logic  prev_req = 1'b0;
  int    run = 0;
  int    cur_len = 0;
  gexp_t cur_g;
  initial forever begin
    @(negedge clk);
    if (mem_req === 1'b1 && !prev_req) begin
      if (gq.size() == 0) fail_evt("unexpected_grant", 64'(grant_id));
      else begin
        cur_g = gq.pop_front();
        chk("grant_id", 64'(grant_id), 64'(cur_g.id));
        chk("mem_addr", mem_addr, cur_g.addr);
        chk("mem_wen", 64'(mem_wen), 64'(cur_g.wen));
        if (cur_g.wen) chk("mem_wdata", 64'(mem_wdata), 64'(cur_g.wdata));
        cur_len = cur_g.len;
      end
      run = 1;
    end else if (mem_req === 1'b1) begin
      run++;
    end
    if (mem_req !== 1'b1 && prev_req && cur_len != 0) chk("busy_len", 64'(run), 64'(cur_len));
    prev_req = (mem_req === 1'b1);
  end

  // Completion monitor.
  aexp_t cur_a;
  initial forever begin
    @(negedge clk);
    if (r_ack !== '0 && !rst) begin
      if (aq.size() == 0) fail_evt("unexpected_ack", 64'(r_ack));
      else begin
        cur_a = aq.pop_front();
        chk("ack_onehot", 64'(r_ack), 64'(oh(cur_a.id)));
        chk("ack_err", 64'(r_err), cur_a.err ? 64'(oh(cur_a.id)) : 64'h0);
        chk("ack_rdata", 64'(r_rdata), 64'(cur_a.rdata));
      end
    end else if (r_err !== '0 && !rst) begin
      fail_evt("err_without_ack", 64'(r_err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_r_ack", 64'(r_ack), 64'h0);
    chk("rst_r_err", 64'(r_err), 64'h0);
    chk("rst_r_rdata", 64'(r_rdata), 64'h0);
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    chk("rst_mem_wen", 64'(mem_wen), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_grant_id", 64'(grant_id), 64'h0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Single read from storage, ack in the third mem_req cycle.
    push_g(DARB_REQ_STORAGE, A2, 1'b0, 8'h00, 3);
    push_a(DARB_REQ_STORAGE, 1'b0, 8'hA5);
    mdly_q.push_back(3);
    set_req(DARB_REQ_STORAGE, 1, A2, 1'b0, 8'h00);
    wait_done("single_read", 100);

    // Write from NIC TX, acked in the first mem_req cycle.
    push_g(DARB_REQ_NIC_TX, A1, 1'b1, 8'h3C, 1);
    push_a(DARB_REQ_NIC_TX, 1'b0, 8'h7D);
    mdly_q.push_back(1);
    set_req(DARB_REQ_NIC_TX, 1, A1, 1'b1, 8'h3C);
    wait_done("write", 100);

    // Contention with burst limit 2: 0,0,1,1,0,0,1,1.
    push_g(0, A0, 1'b0, 8'h00, 2); push_g(0, A0, 1'b0, 8'h00, 2);
    push_g(1, A1, 1'b0, 8'h00, 2); push_g(1, A1, 1'b0, 8'h00, 2);
    push_g(0, A0, 1'b0, 8'h00, 2); push_g(0, A0, 1'b0, 8'h00, 2);
    push_g(1, A1, 1'b0, 8'h00, 2); push_g(1, A1, 1'b0, 8'h00, 2);
    push_a(0, 1'b0, 8'h1C); push_a(0, 1'b0, 8'h1C);
    push_a(1, 1'b0, 8'h7D); push_a(1, 1'b0, 8'h7D);
    push_a(0, 1'b0, 8'h1C); push_a(0, 1'b0, 8'h1C);
    push_a(1, 1'b0, 8'h7D); push_a(1, 1'b0, 8'h7D);
    set_req(0, 4, A0, 1'b0, 8'h00);
    set_req(1, 4, A1, 1'b0, 8'h00);
    wait_done("contention", 300);

    // Burst release and wrap: search from 2 finds 3, then wraps to 0, then 1.
    push_g(3, A3, 1'b0, 8'h00, 2); push_g(0, A0, 1'b0, 8'h00, 2); push_g(1, A1, 1'b0, 8'h00, 2);
    push_a(3, 1'b0, 8'hBF); push_a(0, 1'b0, 8'h1C); push_a(1, 1'b0, 8'h7D);
    set_req(0, 1, A0, 1'b0, 8'h00);
    set_req(1, 1, A1, 1'b0, 8'h00);
    set_req(3, 1, A3, 1'b0, 8'h00);
    wait_done("release", 200);

    // Timeout on storage after 8 BUSY cycles, then the spare requester is served.
    push_g(2, A2, 1'b0, 8'h00, 8); push_a(2, 1'b1, 8'h00);
    push_g(3, A3, 1'b0, 8'h00, 2); push_a(3, 1'b0, 8'hBF);
    mdly_q.push_back(0); mdly_q.push_back(2);
    set_req(2, 1, A2, 1'b0, 8'h00);
    set_req(3, 1, A3, 1'b0, 8'h00);
    wait_done("timeout", 200);

    // Ack lands in the same cycle the timeout would fire: ack wins.
    push_g(1, A1, 1'b0, 8'h00, 8); push_a(1, 1'b0, 8'h7D);
    mdly_q.push_back(8);
    set_req(1, 1, A1, 1'b0, 8'h00);
    wait_done("collision", 100);

    // Reset while BUSY: transfer dropped silently, then lowest index first.
    push_g(2, A2, 1'b0, 8'h00, 0);
    push_g(0, A0, 1'b0, 8'h00, 2); push_g(2, A2, 1'b0, 8'h00, 2);
    push_a(0, 1'b0, 8'h1C); push_a(2, 1'b0, 8'hA5);
    mdly_q.push_back(0);
    set_req(0, 1, A0, 1'b0, 8'h00);
    set_req(2, 1, A2, 1'b0, 8'h00);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(posedge clk); #2;
        seen = (mem_req === 1'b1);
      end
      if (!seen) fail_evt("reset_busy_wait_timeout", 64'(mem_req));
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("midrst_mem_req", 64'(mem_req), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_r_ack", 64'(r_ack), 64'h0);
    chk("midrst_grant_id", 64'(grant_id), 64'h0);
    rst = 1'b0;
    wait_done("reset_busy", 200);

    chk("grant_queue_left", 64'(gq.size()), 64'h0);
    chk("ack_queue_left", 64'(aq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
